// File: rtl/window_seq_ctrl_pkg.sv
// window_seq_ctrl_pkg
// Shared definitions for the window sequencer slice of the HOG pipeline:
//   - seq_state_t : frame sequencer FSM encoding (IDLE/CLEAR/ACTIVE/DONE)
//   - DEF_*       : default frame/window geometry shared with the line-buffer
//                   and cell-histogram blocks
//   - WIN_CNT_W   : width of the emitted-window statistics counter
//   - cnt_width() : counter width for a modulus, never below 1 bit
package window_seq_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_CLEAR  = 2'd1,
        ST_ACTIVE = 2'd2,
        ST_DONE   = 2'd3
    } seq_state_t;

    localparam int DEF_IMG_W = 80;
    localparam int DEF_IMG_H = 60;
    localparam int DEF_KW    = 3;
    localparam int DEF_KH    = 3;

    localparam int WIN_CNT_W = 16;

    // $clog2(1) is 0; keep at least one bit so degenerate geometries still elaborate.
    function automatic int cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/window_seq_ctrl_if.sv
// window_seq_ctrl_if
// Pixel/window handshake and line-buffer control bundle of the window sequencer.
//   i_valid   : upstream pixel valid            (source -> sequencer)
//   i_ready   : upstream pixel accepted          (sequencer -> source)
//   o_valid   : in-bounds window available       (sequencer -> histogram stage)
//   o_ready   : downstream ready for a window    (histogram stage -> sequencer)
//   o_col     : column of window bottom-right pixel
//   o_row     : row of window bottom-right pixel
//   buf_clear : one-cycle line-buffer clear at frame start
//   buf_shift : push current pixel into the line buffer
// Modports: master = sequencer side, slave = source/downstream side.
interface window_seq_ctrl_if
    import window_seq_ctrl_pkg::*;
#(
    parameter int IMG_W = DEF_IMG_W,
    parameter int IMG_H = DEF_IMG_H
);
    localparam int CW = cnt_width(IMG_W);
    localparam int RW = cnt_width(IMG_H);

    logic          i_valid;
    logic          i_ready;
    logic          o_valid;
    logic          o_ready;
    logic [CW-1:0] o_col;
    logic [RW-1:0] o_row;
    logic          buf_clear;
    logic          buf_shift;

    modport master (
        input  i_valid, o_ready,
        output i_ready, o_valid, o_col, o_row, buf_clear, buf_shift
    );

    modport slave (
        output i_valid, o_ready,
        input  i_ready, o_valid, o_col, o_row, buf_clear, buf_shift
    );

endinterface

// File: rtl/window_seq_ctrl_pos_counter.sv
// window_seq_ctrl_pos_counter
// Wrapping column/row position counter over a W x H frame.
//   clk, rst : clock, synchronous active-low reset
//   clr      : synchronous clear to (0,0)
//   adv      : advance one pixel (column first, row on column wrap)
//   col, row : current position
//   last     : current position is the final pixel of the frame
module window_seq_ctrl_pos_counter
    import window_seq_ctrl_pkg::*;
#(
    parameter int W = DEF_IMG_W,
    parameter int H = DEF_IMG_H
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      clr,
    input  logic                      adv,
    output logic [cnt_width(W)-1:0]   col,
    output logic [cnt_width(H)-1:0]   row,
    output logic                      last
);
    localparam int CW = cnt_width(W);
    localparam int RW = cnt_width(H);
    localparam logic [CW-1:0] COL_MAX = CW'(W - 1);
    localparam logic [RW-1:0] ROW_MAX = RW'(H - 1);

    logic [CW-1:0] col_reg, col_next;
    logic [RW-1:0] row_reg, row_next;

    always_comb begin
        col_next = col_reg;
        row_next = row_reg;
        if (clr) begin
            col_next = '0;
            row_next = '0;
        end else if (adv) begin
            if (col_reg == COL_MAX) begin
                col_next = '0;
                // Row wraps together with the column on the last pixel, so
                // the counter is already at (0,0) for the next frame.
                row_next = (row_reg == ROW_MAX) ? '0 : row_reg + RW'(1);
            end else begin
                col_next = col_reg + CW'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            col_reg <= '0;
            row_reg <= '0;
        end else begin
            col_reg <= col_next;
            row_reg <= row_next;
        end
    end

    assign col  = col_reg;
    assign row  = row_reg;
    assign last = (col_reg == COL_MAX) && (row_reg == ROW_MAX);

endmodule

// File: rtl/window_seq_ctrl.sv
// window_seq_ctrl
// Frame-level sequencer for the HOG line-buffer/window datapath. Tracks the
// pixel position over an IMG_W x IMG_H frame, clears the line buffer at frame
// start, gates pixel acceptance, and flags KW x KH windows lying fully inside
// the image (windows that would wrap across a row boundary are never flagged).
// Ports:
//   clk, rst   : clock, synchronous active-low reset
//   start      : begin a frame (only looked at in IDLE)
//   bus        : window_seq_ctrl_if.master (pixel/window handshake, line-buffer ctl)
//   busy       : high in CLEAR/ACTIVE/DONE
//   frame_done : one-cycle pulse after the last pixel is accepted
//   win_count  : emitted-window count
// Build option: define WIN_SEQ_STATS_EN to enable the saturating win_count
// counter; otherwise win_count is tied to 0.
module window_seq_ctrl
    import window_seq_ctrl_pkg::*;
#(
    parameter int IMG_W = DEF_IMG_W,
    parameter int IMG_H = DEF_IMG_H,
    parameter int KW    = DEF_KW,
    parameter int KH    = DEF_KH
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    window_seq_ctrl_if.master    bus,
    output logic                 busy,
    output logic                 frame_done,
    output logic [WIN_CNT_W-1:0] win_count
);
    localparam int CW = cnt_width(IMG_W);
    localparam int RW = cnt_width(IMG_H);

    seq_state_t    state_reg, state_next;
    logic [CW-1:0] col_pos;
    logic [RW-1:0] row_pos;
    logic          last_pos;
    logic          emit;
    logic          ready_int;
    logic          valid_int;
    logic          clear_int;
    logic          accept;

    // A window is complete once the current pixel is at least KH-1 rows down
    // and KW-1 columns across; left-edge pixels would need a wrapped window.
    assign emit = (int'(row_pos) >= KH - 1) && (int'(col_pos) >= KW - 1);

    assign accept = bus.i_valid && ready_int;

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_reg <= ST_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        ready_int  = 1'b0;
        valid_int  = 1'b0;
        clear_int  = 1'b0;
        busy       = 1'b1;
        frame_done = 1'b0;
        case (state_reg)
            ST_IDLE: begin
                busy = 1'b0;
                if (start) begin
                    state_next = ST_CLEAR;
                end
            end
            ST_CLEAR: begin
                clear_int  = 1'b1;
                state_next = ST_ACTIVE;
            end
            ST_ACTIVE: begin
                // Only window-completing pixels wait for the downstream.
                ready_int = !emit || bus.o_ready;
                valid_int = bus.i_valid && emit;
                if (bus.i_valid && ready_int && last_pos) begin
                    state_next = ST_DONE;
                end
            end
            ST_DONE: begin
                frame_done = 1'b1;
                state_next = ST_IDLE;
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    window_seq_ctrl_pos_counter #(
        .W (IMG_W),
        .H (IMG_H)
    ) u_pos (
        .clk  (clk),
        .rst  (rst),
        .clr  (clear_int),
        .adv  (accept),
        .col  (col_pos),
        .row  (row_pos),
        .last (last_pos)
    );

    assign bus.i_ready   = ready_int;
    assign bus.o_valid   = valid_int;
    assign bus.o_col     = col_pos;
    assign bus.o_row     = row_pos;
    assign bus.buf_clear = clear_int;
    assign bus.buf_shift = accept;

`ifdef WIN_SEQ_STATS_EN
    logic [WIN_CNT_W-1:0] win_count_reg;

    // Cleared at frame start and otherwise held, so the count of the last
    // frame stays readable after DONE.
    always_ff @(posedge clk) begin
        if (!rst) begin
            win_count_reg <= '0;
        end else if (clear_int) begin
            win_count_reg <= '0;
        end else if (valid_int && bus.o_ready && (win_count_reg != {WIN_CNT_W{1'b1}})) begin
            win_count_reg <= win_count_reg + WIN_CNT_W'(1);
        end
    end

    assign win_count = win_count_reg;
`else
    assign win_count = '0;
`endif

endmodule

// File: tb/tb_window_seq_ctrl.sv
// tb_window_seq_ctrl
// Self-checking bench for window_seq_ctrl with an 8x4 frame and 3x3 windows.
// A frame-level reference model (linear pixel index, window rule from the
// geometry) predicts every output each cycle; literal checks pin the first
// window position, window count, pulse timing and the stall behaviour.
module tb_window_seq_ctrl;
    import window_seq_ctrl_pkg::*;

    localparam int W  = 8;
    localparam int H  = 4;
    localparam int KW = 3;
    localparam int KH = 3;
    localparam int NWIN = (H - KH + 1) * (W - KW + 1);
`ifdef WIN_SEQ_STATS_EN
    localparam bit STATS = 1'b1;
`else
    localparam bit STATS = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        busy;
    logic        frame_done;
    logic [15:0] win_count;

    always #5 clk = ~clk;

    window_seq_ctrl_if #(.IMG_W(W), .IMG_H(H)) bus ();

    window_seq_ctrl #(.IMG_W(W), .IMG_H(H), .KW(KW), .KH(KH)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .bus        (bus),
        .busy       (busy),
        .frame_done (frame_done),
        .win_count  (win_count)
    );

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d", name, act, exp);
        end
    endtask

    // ---------------- reference model ----------------
    // m_mode: 0 idle, 1 clearing, 2 streaming pixels, 3 frame finished
    int m_mode = 0;
    int m_col  = 0;
    int m_row  = 0;
    int m_win  = 0;
    int cyc    = 0;
    bit cmp_en = 1'b0;

    function automatic bit m_emit();
        return (m_row >= KH - 1) && (m_col >= KW - 1);
    endfunction

    always @(posedge clk) begin
        int p;
        cyc++;
        if (!rst) begin
            m_mode = 0; m_col = 0; m_row = 0; m_win = 0;
        end else begin
            case (m_mode)
                0: if (start) m_mode = 1;
                1: begin m_mode = 2; m_win = 0; end
                2: if (bus.i_valid && (!m_emit() || bus.o_ready)) begin
                    if (m_emit() && m_win < 65535) m_win++;
                    p = m_row * W + m_col + 1;
                    if (p == W * H) begin
                        m_mode = 3;
                        p = 0;
                    end
                    m_col = p % W;
                    m_row = p / W;
                end
                default: m_mode = 0;
            endcase
        end
    end

    // ---------------- monitor / compare ----------------
    int shift_cnt, first_win_acc, clear_cyc, done_cyc, last_shift_cyc;
    bit done_seen;
    int win_q[$];
    int exp_q[$];

    always @(negedge clk) begin
        if (cmp_en) begin
            bit e_ready;
            e_ready = (m_mode == 2) && (!m_emit() || bus.o_ready);
            check("i_ready", bus.i_ready, e_ready);
            check("o_valid", bus.o_valid, (m_mode == 2) && bus.i_valid && m_emit());
            check("buf_shift", bus.buf_shift, e_ready && bus.i_valid);
            check("buf_clear", bus.buf_clear, m_mode == 1);
            check("busy", busy, m_mode != 0);
            check("frame_done", frame_done, m_mode == 3);
            check("win_count", win_count, STATS ? m_win : 0);
            if (bus.o_valid) begin
                check("o_col", bus.o_col, m_col);
                check("o_row", bus.o_row, m_row);
            end
            if (bus.buf_clear) clear_cyc = cyc;
            if (frame_done) begin
                done_cyc  = cyc;
                done_seen = 1'b1;
            end
            if (bus.buf_shift) begin
                shift_cnt++;
                last_shift_cyc = cyc;
                if (bus.o_valid && first_win_acc == 0) first_win_acc = shift_cnt;
            end
            if (bus.o_valid && bus.o_ready) begin
                win_q.push_back(int'(bus.o_row) * 16 + int'(bus.o_col));
                $display("win row=%0d col=%0d cycle=%0d", bus.o_row, bus.o_col, cyc);
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_mon();
        shift_cnt = 0; first_win_acc = 0; clear_cyc = -1; done_cyc = -1;
        last_shift_cyc = -1; done_seen = 1'b0;
        win_q.delete();
    endtask

    int stall_cnt;
    int wrap_acc;

    // mode 0 continuous, 1 row-wrap + backpressure, 2 random i_valid,
    // 3 random i_valid and o_ready, 4 continuous with stray start pulses
    task automatic wait_done(input int mode, input bit keep_start);
        for (int n = 0; n < 400 && !done_seen; n++) begin
            step();
            case (mode)
                1: begin
                    bus.i_valid = 1'b1;
                    if (m_mode == 2 && m_row == 2 && m_col < 2) begin
                        bus.o_ready = 1'b0;
                        @(negedge clk);
                        check("wrap_i_ready", bus.i_ready, 1);
                        check("wrap_o_valid", bus.o_valid, 0);
                        if (bus.buf_shift) wrap_acc++;
                    end else if (m_mode == 2 && m_row == 2 && m_col == 4 && stall_cnt < 5) begin
                        bus.o_ready = 1'b0;
                        stall_cnt++;
                        @(negedge clk);
                        check("stall_i_ready", bus.i_ready, 0);
                        check("stall_shift", bus.buf_shift, 0);
                        check("stall_col", bus.o_col, 4);
                        check("stall_row", bus.o_row, 2);
                    end else begin
                        bus.o_ready = 1'b1;
                    end
                end
                2: begin bus.i_valid = 1'($urandom % 2); bus.o_ready = 1'b1; end
                3: begin bus.i_valid = 1'($urandom % 2); bus.o_ready = 1'($urandom % 2); end
                4: begin bus.i_valid = 1'b1; bus.o_ready = 1'b1; start = 1'($urandom % 2); end
                default: begin bus.i_valid = 1'b1; bus.o_ready = 1'b1; end
            endcase
        end
        if (!done_seen) begin
            @(negedge clk);
        end
        check("frame_finished", done_seen, 1);
        if (!keep_start) start = 1'b0;
        bus.i_valid = 1'b0;
    endtask

    int start_cyc;

    task automatic run_frame(input int mode);
        clear_mon();
        start = 1'b1;
        start_cyc = cyc;
        step();
        start = 1'b0;
        wait_done(mode, 1'b0);
    endtask

    task automatic check_frame(input string tag);
        check({tag, "_win_total"}, win_q.size(), NWIN);
        for (int i = 0; i < NWIN && i < win_q.size(); i++)
            check({tag, "_win_pos"}, win_q[i], exp_q[i]);
        check({tag, "_shifts"}, shift_cnt, W * H);
        check({tag, "_done_lat"}, done_cyc - last_shift_cyc, 1);
    endtask

    int d1;

    initial begin
        for (int r = KH - 1; r < H; r++)
            for (int c = KW - 1; c < W; c++)
                exp_q.push_back(r * 16 + c);

        rst = 1'b0; start = 1'b0; bus.i_valid = 1'b0; bus.o_ready = 1'b0;
        clear_mon();
        step();
        step();
        cmp_en = 1'b1;
        @(negedge clk);
        check("rst_busy", busy, 0);
        check("rst_o_valid", bus.o_valid, 0);
        check("rst_i_ready", bus.i_ready, 0);
        check("rst_col", bus.o_col, 0);
        check("rst_row", bus.o_row, 0);
        check("rst_win_count", win_count, 0);
        step();
        rst = 1'b1;
        step();
        step();

        // Continuous frame
        run_frame(0);
        check("f1_clear_lat", clear_cyc - start_cyc, 1);
        check("f1_first_win_acc", first_win_acc, 19);
        check("f1_first_win", win_q.size() > 0 ? win_q[0] : -1, 2 * 16 + 2);
        check("f1_last_win", win_q.size() > 0 ? win_q[win_q.size() - 1] : -1, 3 * 16 + 7);
        check_frame("f1");
        @(negedge clk);
        check("f1_win_count", win_count, STATS ? 12 : 0);
        step();

        // Row wrap and backpressure
        stall_cnt = 0;
        wrap_acc = 0;
        run_frame(1);
        check("bp_stall_cycles", stall_cnt, 5);
        check("wrap_accepts", wrap_acc, 2);
        check_frame("bp");
        step();

        // Random valid gaps, then random gaps plus random backpressure
        run_frame(2);
        check_frame("gap");
        step();
        run_frame(3);
        check_frame("gap_bp");
        step();

        // Reset mid-frame at (1,5)
        clear_mon();
        start = 1'b1;
        step();
        start = 1'b0;
        bus.i_valid = 1'b1;
        bus.o_ready = 1'b1;
        for (int n = 0; n < 100 && !(m_mode == 2 && m_row == 1 && m_col == 5); n++) step();
        check("mid_reached", (m_row == 1 && m_col == 5), 1);
        rst = 1'b0;
        step();
        bus.i_valid = 1'b0;
        @(negedge clk);
        check("mid_busy", busy, 0);
        check("mid_o_valid", bus.o_valid, 0);
        check("mid_col", bus.o_col, 0);
        check("mid_row", bus.o_row, 0);
        step();
        rst = 1'b1;
        step();
        run_frame(0);
        check_frame("after_rst");
        step();

        // Stray start pulses while active
        run_frame(4);
        check_frame("stray_start");
        step();
        step();

        // start held high: back-to-back frames
        clear_mon();
        start = 1'b1;
        wait_done(0, 1'b1);
        check_frame("held1");
        d1 = done_cyc;
        clear_cyc = -1;
        for (int n = 0; n < 10 && clear_cyc < 0; n++) @(negedge clk);
        check("held_gap", clear_cyc - d1, 2);
        start = 1'b0;
        clear_mon();
        wait_done(0, 1'b0);
        check_frame("held2");
        step();
        step();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/window_seq_ctrl.md
Name: window_seq_ctrl

Overview:
Frame-level sequencer for the line-buffer/window datapath of the HOG pipeline. It tracks pixel row/column over an IMG_W x IMG_H frame and clears the line buffer at frame start. It gates pixel acceptance with a valid/ready handshake. It emits window-valid only for KW x KH windows lying fully inside the image, so row-wrap windows are dropped. It sits between the pixel source and the line buffer / cell-histogram stage.

Parameters:
IMG_W, 80, pixels per row (>= KW)
IMG_H, 60, rows per frame (>= KH)
KW, 3, window width in pixels (>= 1)
KH, 3, window height in rows (>= 1)

Ports:
clk  input  1  clock
rst  input  1  reset, synchronous, active-low
start  input  1  begin a frame; sampled only in IDLE
i_valid  input  1  upstream pixel valid
i_ready  output  1  upstream pixel accepted when i_valid & i_ready
o_ready  input  1  downstream ready for a window
o_valid  output  1  complete in-bounds window available this cycle
o_col  output  $clog2(IMG_W)  column of window's bottom-right pixel
o_row  output  $clog2(IMG_H)  row of window's bottom-right pixel
buf_clear  output  1  one-cycle clear to line buffer
buf_shift  output  1  push current pixel into line buffer (= i_valid & i_ready)
busy  output  1  high in CLEAR/ACTIVE/DONE
frame_done  output  1  one-cycle pulse after last pixel accepted
win_count  output  16  emitted-window count (see Optional Feature)

Behaviour:
- Reset (rst=0 at clk edge): state IDLE, col=row=0. All outputs 0. Reset mid-frame aborts immediately; there is no drain.
- FSM:
  - IDLE: start=1 -> CLEAR.
  - CLEAR: buf_clear=1 for exactly one cycle, i_ready=0 -> ACTIVE.
  - ACTIVE: accept pixels. Accepting the pixel at col=IMG_W-1, row=IMG_H-1 -> DONE.
  - DONE: frame_done=1 for one cycle -> IDLE.
- start while busy is ignored. start held high re-triggers from IDLE after DONE, giving back-to-back frames with a 2-cycle gap (DONE, IDLE).
- emit = (row >= KH-1) & (col >= KW-1). Purely combinational on the current counters.
- In ACTIVE: o_valid = i_valid & emit; i_ready = !emit | o_ready. A non-emitting pixel is never stalled by the downstream.
- In any other state: i_ready=0, o_valid=0.
- o_col/o_row = current col/row, continuously driven. They are only meaningful when o_valid=1.
- On an accepted pixel: col = col+1. At col=IMG_W-1, col wraps to 0 and row increments. row wraps to 0 at the frame end.
- Counters never change without acceptance. i_valid may drop at any time.
- Latency: window valid is combinational with its last pixel, 0 cycles. buf_shift and o_valid assert in the same cycle.
- Simultaneous events:
  - i_valid during CLEAR is not accepted.
  - o_ready=0 on an emitting pixel stalls the pixel; counters and line buffer hold.
- Windows per frame = (IMG_H-KH+1)*(IMG_W-KW+1).

Optional Feature:
Macro WIN_SEQ_STATS_EN.
- Defined: win_count is a 16-bit counter. It clears on buf_clear and increments on o_valid & o_ready, saturating at 0xFFFF. It holds its value after DONE until the next CLEAR. Reset value is 0.
- Undefined: win_count is tied to 0 and no counter logic is synthesized. The port list is identical either way.

Decomposition:
- Shared package/header (hog_pkg):
  - FSM state encoding: IDLE=2'd0, CLEAR=2'd1, ACTIVE=2'd2, DONE=2'd3.
  - Default IMG_W/IMG_H/KW/KH constants shared with the line-buffer and histogram blocks.
- One sub-module: pos_counter, a generic wrapping column/row counter with an advance enable, a last-of-frame flag and a sync clear. The FSM, handshake and stats stay in the top.

Test Plan (IMG_W=8, IMG_H=4, KW=3, KH=3):
- Frame, continuous valid, o_ready=1:
  - buf_clear pulses once, 1 cycle after start.
  - First o_valid on the 19th accepted pixel (row=2, col=2).
  - Exactly 12 windows, the last at (3,7).
  - frame_done exactly 1 cycle after the 32nd accept.
  - win_count=12 with WIN_SEQ_STATS_EN; 0 without.
- Row-wrap check: at (2,0) and (2,1), o_valid=0 and i_ready=1 with o_ready=0 -> pixels accepted, no window emitted.
- Backpressure: o_ready=0 for 5 cycles at (2,4) -> i_ready=0, buf_shift=0, counters hold. On release, a single window is emitted and the pixel is accepted.
- Random i_valid gaps (50%): window count and coordinate sequence match the continuous case. buf_shift count = 32.
- Reset mid-frame at (1,5): next cycle busy=0, o_valid=0, counters 0. A new start yields a full 12-window frame.
- start pulses during ACTIVE ignored. start held high -> second frame's buf_clear appears exactly 2 cycles after the first frame_done.
